mux_arbiter_8rr: RTL



---
 rtl/mux_arbiter_8rr_if.sv | 36 +++
 rtl/mux_arbiter_8rr.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_8rr_if.sv
// mux_arbiter_8rr_if
// Handshake/bus bundle between the 8-way round-robin arbiter and its
// requesters / downstream consumer.
//   req        8  request vector, bit i high while source i wants the bus
//   out_ready  1  consumer accepts the current word this cycle
//   sel        3  registered mux select (index of the granted source)
//   gnt        8  registered one-hot grant, zero when idle
//   out_valid  1  selected word valid (granted and its req still high)
//   busy       1  arbiter holds a grant
// Modports: master = arbiter side, slave = requester/consumer side.
interface mux_arbiter_8rr_if;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out_valid;
    logic       busy;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output gnt,
        output out_valid,
        output busy
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  gnt,
        input  out_valid,
        input  busy
    );
endinterface

// File: rtl/mux_arbiter_8rr.sv
// mux_arbiter_8rr
// Round-robin arbiter owning the select of the shared 16-bit 8:1 mux.
// Each grant is bounded to MAX_HOLD transfers (legal 1..255); a release
// re-searches immediately, so rotation has no bubble cycle.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux_arbiter_8rr_if.master (req, out_ready, sel, gnt, out_valid, busy)
// Build option:
//   ARB_FIXED_PRIO_EN  defined -> search always starts at index 0 (lowest wins),
//                      no rotation pointer is kept.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no grant; gnt=0, waiting for any req bit
// GRANT  | source sel owns the mux; transfers counted in hold_cnt
module mux_arbiter_8rr #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_arbiter_8rr_if.master  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [2:0] ptr_q, ptr_d;
`endif

    logic       xfer;
    logic       release_grant;
    logic [2:0] search_start;
    logic       win_found;
    logic [2:0] win_idx;

    // First set bit of r scanning upward from start, wrapping mod 8.
    function automatic logic [3:0] find_winner(input logic [7:0] r, input logic [2:0] start);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = start + 3'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == ST_GRANT);
    assign bus.out_valid = (state_q == ST_GRANT) && bus.req[sel_q];

    assign xfer          = bus.out_valid && bus.out_ready;
    // A dropped request can never coincide with a transfer, so (a) wins
    // automatically when req and out_ready change on the same edge.
    assign release_grant = !bus.req[sel_q] || (xfer && (hold_cnt_q == HOLD_LAST));

`ifdef ARB_FIXED_PRIO_EN
    assign search_start = 3'd0;
`else
    // On release the pointer becomes sel, so the search starts just past sel.
    assign search_start = (state_q == ST_GRANT) ? sel_q + 3'd1 : ptr_q + 3'd1;
`endif

    assign {win_found, win_idx} = find_winner(bus.req, search_start);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
`ifndef ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_GRANT;
                    sel_d      = win_idx;
                    gnt_d      = 8'b1 << win_idx;
                    hold_cnt_d = 8'd0;
                end
            end
            ST_GRANT: begin
                if (release_grant) begin
`ifndef ARB_FIXED_PRIO_EN
                    ptr_d = sel_q;
`endif
                    if (win_found) begin
                        sel_d      = win_idx;
                        gnt_d      = 8'b1 << win_idx;
                        hold_cnt_d = 8'd0;
                    end else begin
                        // sel is deliberately left at the last owner.
                        state_d    = ST_IDLE;
                        gnt_d      = 8'd0;
                        hold_cnt_d = 8'd0;
                    end
                end else if (xfer) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 3'd0;
            gnt_q      <= 8'd0;
            hold_cnt_q <= 8'd0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q      <= 3'd7;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

endmodule
